// File: rtl/obi_sram_pkg.sv
// Shared types for the OBI-to-SRAM arbiter.
//   owner_e : which core port owns an in-flight response
//   rsp_t   : one-deep response tracker (valid, owner, is_write, err)
package obi_sram_pkg;

    typedef enum logic {
        OwnerInstr = 1'b0,
        OwnerData  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_write;
        logic   err;
    } rsp_t;

endpackage

// File: rtl/obi_rr_arb2.sv
// Two-requester round-robin arbiter with combinational grants.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   req_instr_i, req_data_i   requests from fetch and LSU ports
//   gnt_instr_o, gnt_data_o   one-hot (or zero) grants, same cycle as req
module obi_rr_arb2
    import obi_sram_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_instr_i,
    input  logic req_data_i,
    output logic gnt_instr_o,
    output logic gnt_data_o
);

    owner_e last_q, last_d;

    // Grant decision; a contested cycle goes to the port not granted last.
    always_comb begin
        gnt_instr_o = 1'b0;
        gnt_data_o  = 1'b0;
        last_d      = last_q;
        if (req_instr_i && req_data_i) begin
            if (last_q == OwnerInstr) begin
                gnt_data_o = 1'b1;
            end else begin
                gnt_instr_o = 1'b1;
            end
        end else if (req_instr_i) begin
            gnt_instr_o = 1'b1;
        end else if (req_data_i) begin
            gnt_data_o = 1'b1;
        end
        if (gnt_instr_o) begin
            last_d = OwnerInstr;
        end else if (gnt_data_o) begin
            last_d = OwnerData;
        end
    end

    // Reset as if data won last, so instr takes the first contested cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= OwnerData;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/obi_sram_arbiter.sv
// Arbitrates a core's instr and data OBI ports onto one single-port SRAM.
// Build option: define OBI_SRAM_RANGE_CHECK_EN to return err for accesses
// outside [BaseAddr, BaseAddr + 4*2^AddrWidth); otherwise addresses alias.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   instr_*                fetch port (read only)
//   data_*                 LSU port (read/write with byte enables)
//   sram_*                 SRAM request side; sram_rdata_i valid one cycle
//                          after a read request
module obi_sram_arbiter
    import obi_sram_pkg::*;
#(
    parameter int unsigned AddrWidth = 12,
    parameter logic [31:0] BaseAddr  = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 instr_req_i,
    output logic                 instr_gnt_o,
    output logic                 instr_rvalid_o,
    input  logic [31:0]          instr_addr_i,
    output logic [31:0]          instr_rdata_o,
    output logic                 instr_err_o,

    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [31:0]          data_wdata_i,
    output logic [31:0]          data_rdata_o,
    output logic                 data_err_o,

    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [3:0]           sram_be_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [31:0]          sram_wdata_o,
    input  logic [31:0]          sram_rdata_i
);

    localparam int unsigned TagLsb = AddrWidth + 2;

    logic        gnt_instr;
    logic        gnt_data;
    logic        accept;
    logic        in_range;
    logic        rd_ok;
    logic [31:0] sel_addr;
    logic        unused_bits;
    rsp_t        rsp_d, rsp_q;

    obi_rr_arb2 u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_instr_i (instr_req_i),
        .req_data_i  (data_req_i),
        .gnt_instr_o (gnt_instr),
        .gnt_data_o  (gnt_data)
    );

    assign instr_gnt_o = gnt_instr;
    assign data_gnt_o  = gnt_data;
    assign accept      = gnt_instr | gnt_data;
    assign sel_addr    = gnt_data ? data_addr_i : instr_addr_i;

`ifdef OBI_SRAM_RANGE_CHECK_EN
    // Window is size-aligned, so only the tag bits above it need matching.
    assign in_range    = (sel_addr[31:TagLsb] == BaseAddr[31:TagLsb]);
    assign unused_bits = ^sel_addr[1:0];
`else
    assign in_range    = 1'b1;
    assign unused_bits = ^{sel_addr[31:TagLsb], sel_addr[1:0], BaseAddr};
`endif

    // Forward the accepted request to SRAM; out-of-range requests are dropped.
    always_comb begin
        sram_req_o   = accept & in_range;
        sram_we_o    = sram_req_o & gnt_data & data_we_i;
        sram_be_o    = 4'h0;
        sram_wdata_o = 32'h0;
        sram_addr_o  = sel_addr[TagLsb-1:2];
        if (sram_req_o) begin
            sram_be_o = gnt_data ? data_be_i : 4'hF;
            if (gnt_data) begin
                sram_wdata_o = data_wdata_i;
            end
        end
    end

    // Track the single in-flight response.
    always_comb begin
        rsp_d          = '0;
        rsp_d.valid    = accept;
        rsp_d.owner    = gnt_data ? OwnerData : OwnerInstr;
        rsp_d.is_write = gnt_data & data_we_i;
        rsp_d.err      = accept & ~in_range;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    // Response side: rdata passes SRAM data only for a clean read response.
    always_comb begin
        instr_rvalid_o = rsp_q.valid & (rsp_q.owner == OwnerInstr);
        data_rvalid_o  = rsp_q.valid & (rsp_q.owner == OwnerData);
        rd_ok          = ~rsp_q.is_write & ~rsp_q.err;
        instr_err_o    = instr_rvalid_o & rsp_q.err;
        data_err_o     = data_rvalid_o & rsp_q.err;
        instr_rdata_o  = (instr_rvalid_o && rd_ok) ? sram_rdata_i : 32'h0;
        data_rdata_o   = (data_rvalid_o && rd_ok) ? sram_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_obi_sram_arbiter.sv
// Randomized self-checking bench for obi_sram_arbiter with an SRAM model and
// a behavioural reference model (arbitration pointer, reference memory,
// expected pending response).
module tb_obi_sram_arbiter;

    localparam int unsigned AW      = 12;
    localparam int unsigned WORDS   = 1 << AW;
    localparam logic [31:0] BASE    = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          instr_req_i = 1'b0;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [31:0]   instr_addr_i = '0;
    logic [31:0]   instr_rdata_o;
    logic          instr_err_o;
    logic          data_req_i = 1'b0;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic          data_we_i = 1'b0;
    logic [3:0]    data_be_i = '0;
    logic [31:0]   data_addr_i = '0;
    logic [31:0]   data_wdata_i = '0;
    logic [31:0]   data_rdata_o;
    logic          data_err_o;
    logic          sram_req_o;
    logic          sram_we_o;
    logic [3:0]    sram_be_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_wdata_o;
    logic [31:0]   sram_rdata_q = '0;

    always #5 clk = ~clk;

    obi_sram_arbiter #(.AddrWidth(AW), .BaseAddr(BASE)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .sram_req_o     (sram_req_o),
        .sram_we_o      (sram_we_o),
        .sram_be_o      (sram_be_o),
        .sram_addr_o    (sram_addr_o),
        .sram_wdata_o   (sram_wdata_o),
        .sram_rdata_i   (sram_rdata_q)
    );

    // SRAM model: byte-enabled write, registered read.
    logic [31:0] sram_mem [WORDS];
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
                end
            end else begin
                sram_rdata_q <= sram_mem[sram_addr_o];
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [WORDS];
    int          last_owner;   // 0 = instr, 1 = data
    bit          p_valid;
    int          p_owner;
    bit          p_err;
    logic [31:0] p_rdata;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
`ifdef OBI_SRAM_RANGE_CHECK_EN
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < 4 * (longint'(1) << AW));
`else
        return (a == a);
`endif
    endfunction

    task automatic check_responses();
        bit exp_irv, exp_drv;
        exp_irv = p_valid && (p_owner == 0);
        exp_drv = p_valid && (p_owner == 1);
        check("instr_rvalid", 32'(instr_rvalid_o), 32'(exp_irv));
        check("data_rvalid",  32'(data_rvalid_o),  32'(exp_drv));
        check("instr_rdata",  instr_rdata_o, exp_irv ? p_rdata : 32'h0);
        check("data_rdata",   data_rdata_o,  exp_drv ? p_rdata : 32'h0);
        check("instr_err",    32'(instr_err_o), 32'(exp_irv && p_err));
        check("data_err",     32'(data_err_o),  32'(exp_drv && p_err));
    endtask

    task automatic do_cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                            input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd);
        int          g;
        int          idx;
        bit          ok;
        bit          wr;
        logic [31:0] a;
        @(negedge clk);
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_addr_i  = da;
        data_wdata_i = dwd;
        #1;
        if (ir && dr)  g = (last_owner == 0) ? 1 : 0;
        else if (ir)   g = 0;
        else if (dr)   g = 1;
        else           g = -1;
        a   = (g == 1) ? da : ia;
        ok  = in_window(a);
        idx = int'((a >> 2) % WORDS);
        wr  = (g == 1) && dwe;
        check("instr_gnt", 32'(instr_gnt_o), 32'(g == 0));
        check("data_gnt",  32'(data_gnt_o),  32'(g == 1));
        check_responses();
        check("sram_req", 32'(sram_req_o), 32'(g >= 0 && ok));
        if (g >= 0 && ok) begin
            check("sram_addr",  32'(sram_addr_o), 32'(idx));
            check("sram_we",    32'(sram_we_o),   32'(wr));
            check("sram_be",    32'(sram_be_o),   (g == 1) ? 32'(dbe) : 32'hF);
            if (g == 1) check("sram_wdata", sram_wdata_o, dwd);
        end
        @(posedge clk);
        p_valid = (g >= 0);
        p_owner = g;
        p_err   = (g >= 0) && !ok;
        p_rdata = (g < 0 || wr || !ok) ? 32'h0 : ref_mem[idx];
        if (g >= 0 && ok && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (dbe[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
            end
        end
        if (g >= 0) last_owner = g;
    endtask

    task automatic idle_cycle();
        do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_ni      = 1'b0;
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        data_we_i   = 1'b0;
        #1;
        check("rst_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        check("rst_data_rvalid",  32'(data_rvalid_o),  32'h0);
        check("rst_instr_err",    32'(instr_err_o),    32'h0);
        check("rst_data_err",     32'(data_err_o),     32'h0);
        check("rst_instr_rdata",  instr_rdata_o,       32'h0);
        check("rst_data_rdata",   data_rdata_o,        32'h0);
        check("rst_sram_req",     32'(sram_req_o),     32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni     = 1'b1;
        p_valid    = 1'b0;
        p_owner    = 0;
        p_err      = 1'b0;
        p_rdata    = 32'h0;
        last_owner = 1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 31)) << 2;
        a = a | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_C000);
        return a;
    endfunction

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        sram_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;
        last_owner = 1;
        p_valid    = 1'b0;
        p_owner    = 0;
        p_err      = 1'b0;
        p_rdata    = 32'h0;

        apply_reset();

        // Lone instr read of word 4.
        do_cycle(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle_cycle();
        check("instr_rd_word4_value", ref_mem[4], 32'hDEAD_BEEF);

        // Partial data write then read it back.
        do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0008, 32'h1234_5678);
        do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
        idle_cycle();

        // Address just past the window.
        do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_4000, 32'h0);
        idle_cycle();

        // Reset right after an accepted instr read; then contest for 6 cycles.
        do_cycle(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b1, 32'(i) << 2, 1'b1, 1'b0, 4'hF, 32'(i + 8) << 2, 32'h0);
        end
        idle_cycle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            do_cycle(1'($urandom_range(0, 1)), rand_addr(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom), rand_addr(), $urandom);
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
